// File: rtl/mulu_acc_drain_pkg.sv
// Shared definitions for the multiply-accumulate-drain slice.
// Holds the upstream 2x2 multiplier widths, accumulator defaults and FSM encodings.
// No logic; imported by mulu_acc_drain and acc_nib_ser.
package mulu_acc_drain_pkg;

    // Upstream top_mulu_x2y2 operand widths; its product width follows.
    localparam int MUL_X_WIDTH   = 2;
    localparam int MUL_Y_WIDTH   = 2;
    localparam int P_WIDTH_DEF   = MUL_X_WIDTH + MUL_Y_WIDTH;

    // Accumulator width must be a whole number of nibbles.
    localparam int ACC_WIDTH_DEF = 8;
    localparam int NIB_WIDTH     = 4;

    // Products per batch (1..31) and the width of the batch counter.
    localparam int COUNT_MAX_DEF = 31;
    localparam int CNT_WIDTH     = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACC   = 2'd1,
        ST_DRAIN = 2'd2
    } acc_state_e;

    // Number of nibbles needed to drain an accumulator of the given width.
    function automatic int nib_count(input int acc_w);
        return acc_w / NIB_WIDTH;
    endfunction

endpackage

// File: rtl/mulu_acc_drain_nib_ser.sv
// acc_nib_ser: serialises a loaded accumulator value as nibbles, least significant first.
// Latency: nibble 0 is on o_nib the cycle after i_load; one nibble per cycle thereafter.
// Backpressure: none; the consumer must accept every nibble while o_nib_vld is high.
// Ports: clk/rst (sync, active-low) | i_load, i_load_dat: capture a value and start
//        | o_nib, o_nib_vld, o_nib_last: registered nibble stream.
module acc_nib_ser
    import mulu_acc_drain_pkg::*;
#(
    parameter int ACC_WIDTH = ACC_WIDTH_DEF
)
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_load,
    input  logic [ACC_WIDTH-1:0] i_load_dat,
    output logic [3:0]           o_nib,
    output logic                 o_nib_vld,
    output logic                 o_nib_last
);

    localparam int NNIB  = nib_count(ACC_WIDTH);
    localparam int IDX_W = (NNIB > 1) ? $clog2(NNIB) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NNIB - 1);

    logic [ACC_WIDTH-1:0] r_sh;
    logic [IDX_W-1:0]     r_idx;
    logic [3:0]           r_nib;
    logic                 r_vld;
    logic                 r_last;

    logic [ACC_WIDTH-1:0] w_sh_nxt;
    logic [IDX_W-1:0]     w_idx_inc;

    // The shift register always holds the value whose low nibble is on o_nib.
    assign w_sh_nxt  = r_sh >> NIB_WIDTH;
    assign w_idx_inc = r_idx + IDX_W'(1);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sh   <= '0;
            r_idx  <= '0;
            r_nib  <= '0;
            r_vld  <= 1'b0;
            r_last <= 1'b0;
        end else if (i_load) begin
            r_sh   <= i_load_dat;
            r_idx  <= '0;
            r_nib  <= i_load_dat[3:0];
            r_vld  <= 1'b1;
            r_last <= (IDX_LAST == '0);
        end else if (r_vld && !r_last) begin
            r_sh   <= w_sh_nxt;
            r_idx  <= w_idx_inc;
            r_nib  <= w_sh_nxt[3:0];
            r_vld  <= 1'b1;
            r_last <= (w_idx_inc == IDX_LAST);
        end else begin
            // Idle or just emitted the last nibble: outputs return to zero.
            r_nib  <= '0;
            r_vld  <= 1'b0;
            r_last <= 1'b0;
        end
    end

    assign o_nib      = r_nib;
    assign o_nib_vld  = r_vld;
    assign o_nib_last = r_last;

endmodule

// File: rtl/mulu_acc_drain.sv
// mulu_acc_drain: accumulates unsigned products from top_mulu_x2y2 (p_vld = its rdy)
// and drains the batch sum as nibbles after COUNT_MAX products or on flush.
// Latency: last accepted product (or flush) to first nib_vld is 1 cycle.
// Backpressure: none upstream; products arriving during a drain are dropped and flagged.
// Ports: clk, rst (sync, active-low) | p, p_vld, flush in | nib, nib_vld, nib_last,
//        ovf (sticky carry-out), drop (sticky lost product), busy out. All outputs registered.
module mulu_acc_drain
    import mulu_acc_drain_pkg::*;
#(
    parameter int P_WIDTH   = P_WIDTH_DEF,
    parameter int ACC_WIDTH = ACC_WIDTH_DEF,
    parameter int COUNT_MAX = COUNT_MAX_DEF
)
(
    input  logic               clk,
    input  logic               rst,
    input  logic [P_WIDTH-1:0] p,
    input  logic               p_vld,
    input  logic               flush,
    output logic [3:0]         nib,
    output logic               nib_vld,
    output logic               nib_last,
    output logic               ovf,
    output logic               drop,
    output logic               busy
);

    acc_state_e           r_state;
    acc_state_e           w_state_nxt;

    logic [ACC_WIDTH-1:0] r_acc;
    logic [ACC_WIDTH-1:0] w_acc_nxt;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic [CNT_WIDTH-1:0] w_cnt_nxt;
    logic [CNT_WIDTH-1:0] w_cnt_inc;
    logic                 r_ovf;
    logic                 w_ovf_nxt;
    logic                 r_drop;
    logic                 w_drop_nxt;
    logic                 r_busy;

    logic [ACC_WIDTH:0]   w_sum;
    logic                 w_load;
    logic                 w_ser_last;

    // One extra bit on the adder gives the carry-out for ovf.
    assign w_sum     = {1'b0, r_acc} + (ACC_WIDTH + 1)'(p);
    assign w_cnt_inc = r_cnt + CNT_WIDTH'(1);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, datapath updates and serializer load.
    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_cnt_nxt   = r_cnt;
        w_ovf_nxt   = r_ovf;
        w_drop_nxt  = r_drop;
        w_load      = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                // flush alone is meaningless here: nothing has been accumulated.
                if (p_vld) begin
                    w_acc_nxt  = ACC_WIDTH'(p);
                    w_cnt_nxt  = CNT_WIDTH'(1);
                    w_ovf_nxt  = 1'b0;
                    w_drop_nxt = 1'b0;
                    if (COUNT_MAX == 1) begin
                        w_state_nxt = ST_DRAIN;
                        w_load      = 1'b1;
                    end else begin
                        w_state_nxt = ST_ACC;
                    end
                end
            end

            ST_ACC: begin
                if (p_vld) begin
                    w_acc_nxt = w_sum[ACC_WIDTH-1:0];
                    w_cnt_nxt = w_cnt_inc;
                    if (w_sum[ACC_WIDTH]) begin
                        w_ovf_nxt = 1'b1;
                    end
                end
                // The serializer loads the post-add value, so a product arriving
                // with flush is included and nib_vld follows one cycle later.
                if (flush || (p_vld && (w_cnt_inc == CNT_WIDTH'(COUNT_MAX)))) begin
                    w_state_nxt = ST_DRAIN;
                    w_load      = 1'b1;
                end
            end

            ST_DRAIN: begin
                if (p_vld) begin
                    w_drop_nxt = 1'b1;
                end
                // DRAIN cycles coincide with nibble cycles; leave after the last.
                if (w_ser_last) begin
                    w_state_nxt = ST_IDLE;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Datapath and status registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_acc  <= '0;
            r_cnt  <= '0;
            r_ovf  <= 1'b0;
            r_drop <= 1'b0;
            r_busy <= 1'b0;
        end else begin
            r_acc  <= w_acc_nxt;
            r_cnt  <= w_cnt_nxt;
            r_ovf  <= w_ovf_nxt;
            r_drop <= w_drop_nxt;
            r_busy <= (w_state_nxt != ST_IDLE);
        end
    end

    acc_nib_ser #(
        .ACC_WIDTH (ACC_WIDTH)
    ) u_nib_ser (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_load_dat (w_acc_nxt),
        .o_nib      (nib),
        .o_nib_vld  (nib_vld),
        .o_nib_last (w_ser_last)
    );

    assign nib_last = w_ser_last;
    assign ovf      = r_ovf;
    assign drop     = r_drop;
    assign busy     = r_busy;

endmodule
